// File: rtl/sram_match_scanner.sv
// Rotating SRAM scanner: presents one registered candidate per port per cycle
// and owns the SRAM occupancy table that arbitrates matcher claims.
module sram_match_scanner #(
  parameter int SRAM_NUM = 32,
  parameter int PORT_NUM = 16,
  parameter int STRIDE   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SRAM_NUM*11-1:0] sram_free_space,
  output logic [PORT_NUM*5-1:0]  scan_sram,
  input  logic [PORT_NUM*9-1:0]  amount_in,
  output logic [PORT_NUM*5-1:0]  match_sram,
  output logic [PORT_NUM-1:0]    accessible,
  output logic [PORT_NUM*11-1:0] free_space,
  output logic [PORT_NUM*9-1:0]  packet_amount,
  input  logic [PORT_NUM-1:0]    match_suc,
  input  logic [PORT_NUM*6-1:0]  match_best_sram,
  output logic [PORT_NUM-1:0]    match_nack,
  input  logic [PORT_NUM-1:0]    release_req,
  output logic [PORT_NUM*6-1:0]  held_sram
);
  localparam int IW = 5;
  localparam int HW = IW + 1;
  localparam int PW = 4;
  localparam logic [HW-1:0] NONE = HW'(SRAM_NUM);

  logic [IW-1:0]       tick_q, tick_d;
  logic [SRAM_NUM-1:0] own_vld_q, own_vld_d;
  logic [PW-1:0]       own_port_q [SRAM_NUM];
  logic [PW-1:0]       own_port_d [SRAM_NUM];
  logic [HW-1:0]       held_q [PORT_NUM];
  logic [HW-1:0]       held_d [PORT_NUM];
  logic [PORT_NUM-1:0] nack_q, nack_d;
  logic [PORT_NUM-1:0] acc_q, acc_d;
  logic [IW-1:0]       msram_q [PORT_NUM];
  logic [IW-1:0]       msram_d [PORT_NUM];
  logic [10:0]         free_q [PORT_NUM];
  logic [10:0]         free_d [PORT_NUM];
  logic [8:0]          amt_q [PORT_NUM];
  logic [8:0]          amt_d [PORT_NUM];

  logic [IW-1:0] scan_idx [PORT_NUM];
  logic [HW-1:0] best [PORT_NUM];
  logic [10:0]   fs_arr [SRAM_NUM];
  logic [IW-1:0] claim_s;

  always_comb begin
    tick_d = tick_q + 1'b1;
    for (int i = 0; i < SRAM_NUM; i++) fs_arr[i] = sram_free_space[i*11 +: 11];
    for (int p = 0; p < PORT_NUM; p++) begin
      scan_idx[p] = tick_q + IW'(STRIDE * p);
      best[p]     = match_best_sram[p*HW +: HW];
    end
  end

  // Releases are applied first so that a claim in the same cycle (from the
  // releasing port or any other) sees the freed SRAM. Claims are then resolved
  // in ascending port order, which gives the lowest port priority on collisions.
  always_comb begin
    own_vld_d  = own_vld_q;
    own_port_d = own_port_q;
    held_d     = held_q;
    nack_d     = '0;
    claim_s    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (release_req[p] && held_q[p] < NONE) begin
        own_vld_d[held_q[p][IW-1:0]] = 1'b0;
        held_d[p] = NONE;
      end
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      if (match_suc[p] && best[p] < NONE) begin
        claim_s = best[p][IW-1:0];
        if (own_vld_d[claim_s] && own_port_d[claim_s] != PW'(p)) begin
          nack_d[p] = 1'b1;
        end else begin
          if (held_d[p] < NONE && held_d[p][IW-1:0] != claim_s)
            own_vld_d[held_d[p][IW-1:0]] = 1'b0;
          own_vld_d[claim_s]  = 1'b1;
          own_port_d[claim_s] = PW'(p);
          held_d[p]           = {1'b0, claim_s};
        end
      end
    end
  end

  // Accessibility is judged against the post-claim table to avoid a stale grant.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      msram_d[p] = scan_idx[p];
      free_d[p]  = fs_arr[scan_idx[p]];
      amt_d[p]   = amount_in[p*9 +: 9];
      acc_d[p]   = !own_vld_d[scan_idx[p]] || (own_port_d[scan_idx[p]] == PW'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= '0;
      own_vld_q <= '0;
      nack_q    <= '0;
      acc_q     <= '0;
      for (int i = 0; i < SRAM_NUM; i++) own_port_q[i] <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        held_q[p]  <= NONE;
        msram_q[p] <= '0;
        free_q[p]  <= '0;
        amt_q[p]   <= '0;
      end
    end else begin
      tick_q     <= tick_d;
      own_vld_q  <= own_vld_d;
      own_port_q <= own_port_d;
      held_q     <= held_d;
      nack_q     <= nack_d;
      acc_q      <= acc_d;
      msram_q    <= msram_d;
      free_q     <= free_d;
      amt_q      <= amt_d;
    end
  end

  always_comb begin
    match_nack = nack_q;
    accessible = acc_q;
    for (int p = 0; p < PORT_NUM; p++) begin
      scan_sram[p*IW +: IW]   = scan_idx[p];
      match_sram[p*IW +: IW]  = msram_q[p];
      free_space[p*11 +: 11]  = free_q[p];
      packet_amount[p*9 +: 9] = amt_q[p];
      held_sram[p*HW +: HW]   = held_q[p];
    end
  end

endmodule

// File: tb/tb_sram_match_scanner.sv
// Bench for sram_match_scanner: directed claim/release vectors, mid-claim reset
// and randomized traffic, all checked against an integer ownership model.
module tb_sram_match_scanner;
  localparam int SN = 32;
  localparam int PN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SN*11-1:0] sram_free_space;
  logic [PN*5-1:0]  scan_sram;
  logic [PN*9-1:0]  amount_in;
  logic [PN*5-1:0]  match_sram;
  logic [PN-1:0]    accessible;
  logic [PN*11-1:0] free_space;
  logic [PN*9-1:0]  packet_amount;
  logic [PN-1:0]    match_suc;
  logic [PN*6-1:0]  match_best_sram;
  logic [PN-1:0]    match_nack;
  logic [PN-1:0]    release_req;
  logic [PN*6-1:0]  held_sram;

  sram_match_scanner dut (
    .clk(clk), .rst_n(rst_n), .sram_free_space(sram_free_space),
    .scan_sram(scan_sram), .amount_in(amount_in), .match_sram(match_sram),
    .accessible(accessible), .free_space(free_space),
    .packet_amount(packet_amount), .match_suc(match_suc),
    .match_best_sram(match_best_sram), .match_nack(match_nack),
    .release_req(release_req), .held_sram(held_sram)
  );

  int checks = 0;
  int errors = 0;

  // stimulus arrays
  int fs[SN];
  int amt[PN];
  bit suc[PN];
  int best[PN];
  bit rel[PN];

  // reference model: owner[s] = port or -1, held[p] = sram or 32
  int m_tick;
  int m_owner[SN];
  int m_held[PN];
  int m_ms[PN], m_acc[PN], m_free[PN], m_amt[PN], m_nack[PN];

  typedef struct {
    int cp0, cs0, cp1, cs1, rp;
    int hp0, hv0, hp1, hv1, np, nv;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < SN; i++) sram_free_space[i*11 +: 11] = 11'(fs[i]);
    for (int p = 0; p < PN; p++) begin
      amount_in[p*9 +: 9]       = 9'(amt[p]);
      match_suc[p]              = suc[p];
      match_best_sram[p*6 +: 6] = 6'(best[p]);
      release_req[p]            = rel[p];
    end
  endtask

  task automatic clear_req();
    for (int p = 0; p < PN; p++) begin
      suc[p] = 1'b0; best[p] = 0; rel[p] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_tick = 0;
    for (int s = 0; s < SN; s++) m_owner[s] = -1;
    for (int p = 0; p < PN; p++) begin
      m_held[p] = 32; m_ms[p] = 0; m_acc[p] = 0; m_free[p] = 0; m_amt[p] = 0; m_nack[p] = 0;
    end
  endtask

  task automatic model_step();
    int s, sc;
    for (int p = 0; p < PN; p++) begin
      m_nack[p] = 0;
      if (rel[p] && m_held[p] != 32) begin
        m_owner[m_held[p]] = -1;
        m_held[p] = 32;
      end
    end
    for (int p = 0; p < PN; p++) begin
      if (suc[p] && best[p] < 32) begin
        s = best[p];
        if (m_owner[s] != -1 && m_owner[s] != p) m_nack[p] = 1;
        else begin
          if (m_held[p] != 32 && m_held[p] != s) m_owner[m_held[p]] = -1;
          m_owner[s] = p;
          m_held[p] = s;
        end
      end
    end
    for (int p = 0; p < PN; p++) begin
      sc = (m_tick + 2 * p) % 32;
      m_ms[p]   = sc;
      m_free[p] = fs[sc];
      m_amt[p]  = amt[p];
      m_acc[p]  = (m_owner[sc] == -1 || m_owner[sc] == p) ? 1 : 0;
    end
    m_tick = (m_tick + 1) % 32;
  endtask

  task automatic check_all();
    int dup = 0;
    for (int p = 0; p < PN; p++) begin
      chk($sformatf("scan_sram[%0d]", p), int'(scan_sram[p*5 +: 5]), (m_tick + 2 * p) % 32);
      chk($sformatf("match_sram[%0d]", p), int'(match_sram[p*5 +: 5]), m_ms[p]);
      chk($sformatf("accessible[%0d]", p), int'(accessible[p]), m_acc[p]);
      chk($sformatf("free_space[%0d]", p), int'(free_space[p*11 +: 11]), m_free[p]);
      chk($sformatf("packet_amount[%0d]", p), int'(packet_amount[p*9 +: 9]), m_amt[p]);
      chk($sformatf("match_nack[%0d]", p), int'(match_nack[p]), m_nack[p]);
      chk($sformatf("held_sram[%0d]", p), int'(held_sram[p*6 +: 6]), m_held[p]);
    end
    for (int p = 0; p < PN; p++)
      for (int q = p + 1; q < PN; q++)
        if (held_sram[p*6 +: 6] < 6'd32 && held_sram[p*6 +: 6] == held_sram[q*6 +: 6]) dup++;
    chk("held_unique", dup, 0);
  endtask

  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // {cp0,cs0,cp1,cs1,rp, hp0,hv0,hp1,hv1, np,nv}
    vecs[0] = '{2, 9, -1, 0, -1,   2, 9,  1, 32,  2, 0};
    vecs[1] = '{1, 12, 5, 12, -1,  1, 12, 5, 32,  5, 1};
    vecs[2] = '{2, 20, -1, 0, -1,  2, 20, 1, 12,  2, 0};
    vecs[3] = '{4, 7, -1, 0, -1,   4, 7,  2, 20,  4, 0};
    vecs[4] = '{6, 7, -1, 0, 4,    6, 7,  4, 32,  6, 0};
    vecs[5] = '{3, 20, -1, 0, -1,  3, 32, 2, 20,  3, 1};
    vecs[6] = '{3, 40, -1, 0, -1,  3, 32, 2, 20,  3, 0};
    vecs[7] = '{-1, 0, -1, 0, 0,   0, 32, 6, 7,   0, 0};
    vecs[8] = '{1, 13, -1, 0, 1,   1, 13, 5, 32,  1, 0};
    vecs[9] = '{5, 13, 7, 12, -1,  7, 12, 5, 32,  5, 1};

    for (int i = 0; i < SN; i++) fs[i] = 100;
    for (int p = 0; p < PN; p++) amt[p] = p;
    clear_req();
    drive();
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    cycle();
    chk("port0_first_match", int'(match_sram[0 +: 5]), 0);
    chk("port3_first_match", int'(match_sram[15 +: 5]), 6);
    repeat (39) cycle();

    for (int v = 0; v < 10; v++) begin
      clear_req();
      if (vecs[v].cp0 >= 0) begin suc[vecs[v].cp0] = 1'b1; best[vecs[v].cp0] = vecs[v].cs0; end
      if (vecs[v].cp1 >= 0) begin suc[vecs[v].cp1] = 1'b1; best[vecs[v].cp1] = vecs[v].cs1; end
      if (vecs[v].rp >= 0) rel[vecs[v].rp] = 1'b1;
      cycle();
      chk($sformatf("vec%0d_held_a", v), int'(held_sram[vecs[v].hp0*6 +: 6]), vecs[v].hv0);
      chk($sformatf("vec%0d_held_b", v), int'(held_sram[vecs[v].hp1*6 +: 6]), vecs[v].hv1);
      chk($sformatf("vec%0d_nack", v), int'(match_nack[vecs[v].np]), vecs[v].nv);
    end
    clear_req();
    repeat (34) cycle();

    // asynchronous reset in the middle of a claim with four SRAMs owned
    suc[8] = 1'b1; best[8] = 3;
    drive();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    clear_req();
    drive();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("scan_restart", int'(scan_sram[0 +: 5]), 0);
    check_all();

    repeat (400) begin
      for (int i = 0; i < SN; i++) fs[i] = int'($urandom_range(0, 2047));
      for (int p = 0; p < PN; p++) begin
        amt[p]  = int'($urandom_range(0, 511));
        suc[p]  = ($urandom_range(0, 3) == 0);
        best[p] = int'($urandom_range(0, 39));
        rel[p]  = ($urandom_range(0, 7) == 0);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
